// File: rtl/l2_port_pkg.sv
// Shared types and widths for the L2 line-port arbiter.
package l2_port_pkg;
    localparam int L2_ADDR_W    = 32;
    localparam int L2_LINE_SIZE = 64;
    localparam int LINE_W       = L2_LINE_SIZE * 8;

    typedef enum logic {IDLE, WAIT} l2arb_state_t;
    typedef enum logic {OWN_I, OWN_D} l2arb_owner_t;

    // Result of the priority pick: whether anyone wins, who, and whether it came from a D lock.
    typedef struct packed {
        logic         valid;
        l2arb_owner_t owner;
        logic         locked;
    } l2arb_pick_t;
endpackage

// File: rtl/l2_port_arbiter.sv
// Shares the single L2 line port between the L1 I-cache and D-cache controllers.
// D wins by default; a streak limit keeps I from starving; D can lock the port across two requests.
module l2_port_arbiter
    import l2_port_pkg::*;
#(
    parameter int LINE_SIZE      = LINE_W / 8,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req,
    input  logic [L2_ADDR_W-1:0]   i_addr,
    output logic                   i_gnt,
    output logic                   i_dvalid,
    output logic                   i_err,
    input  logic                   d_req,
    input  logic                   d_we,
    input  logic [L2_ADDR_W-1:0]   d_addr,
    input  logic [LINE_SIZE*8-1:0] d_wdata,
    input  logic                   d_lock,
    output logic                   d_gnt,
    output logic                   d_dvalid,
    output logic                   d_err,
    output logic [LINE_SIZE*8-1:0] rdata,
    output logic                   l2_req,
    output logic                   l2_we,
    output logic [L2_ADDR_W-1:0]   l2_addr,
    output logic [LINE_SIZE*8-1:0] l2_write_data,
    input  logic [LINE_SIZE*8-1:0] l2_read_data,
    input  logic                   l2_data_valid,
    input  logic                   l2_ready
);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);

    l2arb_state_t        state;
    l2arb_state_t        next_state;
    l2arb_owner_t        owner;
    logic [STREAK_W-1:0] streak;
    logic [TIMER_W-1:0]  timer;
    logic                lock_pend;
    logic                first_idle;
    l2arb_pick_t         pick;
    logic                grant;
    logic                complete;
    logic                timeout;

    // Fixed priority: locked D, then a starved I, then D, then I.
    function automatic l2arb_pick_t pick_winner(input logic lock_p, input logic i_starved,
                                                input logic i_rq, input logic d_rq);
        l2arb_pick_t p;
        p.valid  = i_rq | d_rq;
        p.owner  = OWN_I;
        p.locked = 1'b0;
        if (lock_p && d_rq) begin
            p.owner  = OWN_D;
            p.locked = 1'b1;
        end else if (i_rq && i_starved) begin
            p.owner = OWN_I;
        end else if (d_rq) begin
            p.owner = OWN_D;
        end
        return p;
    endfunction

    always_comb begin
        pick       = pick_winner(lock_pend, streak == STREAK_MAX, i_req, d_req);
        next_state = state;
        grant      = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (l2_ready && pick.valid) begin
                    grant      = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (l2_data_valid) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end else if (timer == TIMER_MAX) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pulses are gated by rst_n so every output reads 0 while reset is held.
    assign i_gnt    = rst_n & grant & (pick.owner == OWN_I);
    assign d_gnt    = rst_n & grant & (pick.owner == OWN_D);
    assign i_dvalid = rst_n & complete & (owner == OWN_I);
    assign d_dvalid = rst_n & complete & (owner == OWN_D);
    assign i_err    = rst_n & timeout & (owner == OWN_I);
    assign d_err    = rst_n & timeout & (owner == OWN_D);
    assign rdata    = (rst_n && complete) ? l2_read_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            owner         <= OWN_I;
            streak        <= '0;
            timer         <= '0;
            lock_pend     <= 1'b0;
            first_idle    <= 1'b0;
            l2_req        <= 1'b0;
            l2_we         <= 1'b0;
            l2_addr       <= '0;
            l2_write_data <= '0;
        end else begin
            state      <= next_state;
            l2_req     <= grant;
            first_idle <= complete | timeout;
            timer      <= (state == WAIT && next_state == WAIT) ? timer + 1'b1 : '0;

            if (grant) begin
                owner         <= pick.owner;
                l2_we         <= (pick.owner == OWN_D) & d_we;
                l2_addr       <= (pick.owner == OWN_D) ? d_addr : i_addr;
                l2_write_data <= (pick.owner == OWN_D) ? d_wdata : '0;
                lock_pend     <= (pick.owner == OWN_D) & d_lock;
            end else if (state == IDLE && first_idle && !d_req) begin
                lock_pend <= 1'b0;
            end

            // A locked D grant leaves the streak alone so the lock pair counts once against I.
            if (state == IDLE) begin
                if (!i_req || (grant && pick.owner == OWN_I)) begin
                    streak <= '0;
                end else if (grant && !pick.locked && streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: reset, vector table, directed corner cases and random traffic.
module tb_l2_port_arbiter;
    import l2_port_pkg::*;

    localparam int LW   = LINE_W;
    localparam int MAXS = 4;
    localparam int TO   = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req, i_gnt, i_dvalid, i_err;
    logic          d_req, d_we, d_lock, d_gnt, d_dvalid, d_err;
    logic          l2_req, l2_we, l2_data_valid, l2_ready;
    logic [31:0]   i_addr, d_addr, l2_addr;
    logic [LW-1:0] d_wdata, rdata, l2_write_data, l2_read_data;

    l2_port_arbiter #(.LINE_SIZE(LW / 8), .MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_dvalid(i_dvalid), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt), .d_dvalid(d_dvalid), .d_err(d_err), .rdata(rdata),
        .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_write_data(l2_write_data),
        .l2_read_data(l2_read_data), .l2_data_valid(l2_data_valid), .l2_ready(l2_ready)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    last_cyc;
    string order;
    bit    last_igt, last_dgt, last_idv, last_ddv, last_der, last_l2req;

    // Reference model: one outstanding transaction, grant history reduced to a streak count.
    bit            m_busy, m_own_d, m_lock, m_after, m_l2req, m_we;
    int            m_waited, m_streak;
    logic [31:0]   m_addr;
    logic [LW-1:0] m_wdata;
    bit            e_grant, e_win_d, e_locked, e_igt, e_dgt, e_idv, e_ddv, e_ier, e_der;
    logic [LW-1:0] e_rdata;

    // Requester and L2 environment
    typedef struct {
        bit            we;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        bit            lock;
    } dreq_t;
    dreq_t       dq[$];
    bit          i_want;
    logic [31:0] i_next_addr;
    bit          rdy;
    bit          l2_auto;
    int          l2_lat;
    int          l2_cd;
    bit          stray_dv;

    typedef struct {
        bit          ir;
        bit          dr;
        bit          dv;
        bit          e_igt;
        bit          e_dgt;
        bit          e_l2req;
        bit          e_idv;
        bit          e_ddv;
        logic [31:0] e_addr;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [LW-1:0] rndLine();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkText(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_busy = 0; m_own_d = 0; m_lock = 0; m_after = 0; m_l2req = 0; m_we = 0;
        m_waited = 0; m_streak = 0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic modelEval();
        e_grant = 0; e_win_d = 0; e_locked = 0;
        e_igt = 0; e_dgt = 0; e_idv = 0; e_ddv = 0; e_ier = 0; e_der = 0;
        e_rdata = '0;
        if (rst_n !== 1'b1) return;
        if (!m_busy) begin
            if (l2_ready && (i_req || d_req)) begin
                e_grant = 1;
                if (m_lock && d_req) begin
                    e_win_d  = 1;
                    e_locked = 1;
                end else if (i_req && m_streak >= MAXS) begin
                    e_win_d = 0;
                end else begin
                    e_win_d = d_req;
                end
                e_igt = !e_win_d;
                e_dgt = e_win_d;
            end
        end else if (l2_data_valid) begin
            e_idv   = !m_own_d;
            e_ddv   = m_own_d;
            e_rdata = l2_read_data;
        end else if (m_waited >= TO) begin
            e_ier = !m_own_d;
            e_der = m_own_d;
        end
    endtask

    task automatic modelClock();
        if (rst_n !== 1'b1) begin
            modelReset();
            return;
        end
        if (!m_busy) begin
            m_l2req = e_grant;
            if (e_grant) begin
                m_busy   = 1;
                m_waited = 0;
                m_own_d  = e_win_d;
                m_we     = e_win_d & d_we;
                m_addr   = e_win_d ? d_addr : i_addr;
                m_wdata  = e_win_d ? d_wdata : '0;
                m_lock   = e_win_d & d_lock;
            end else if (m_after && !d_req) begin
                m_lock = 0;
            end
            if (!i_req || (e_grant && !e_win_d)) m_streak = 0;
            else if (e_grant && !e_locked) m_streak = (m_streak + 1 > MAXS) ? MAXS : m_streak + 1;
            m_after = 0;
        end else begin
            m_l2req = 0;
            if (e_idv || e_ddv || e_ier || e_der) begin
                m_busy  = 0;
                m_after = 1;
            end else begin
                m_waited++;
            end
        end
    endtask

    task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                                 input logic [31:0] da, input logic [LW-1:0] dwd, input bit dl,
                                 input bit rdy_in, input bit dv);
        i_req         = ir;
        i_addr        = ia;
        d_req         = dr;
        d_we          = dwe;
        d_addr        = da;
        d_wdata       = dwd;
        d_lock        = dl;
        l2_ready      = rdy_in;
        l2_data_valid = dv;
        l2_read_data  = rndLine();
    endtask

    // One clock: compare everything against the model before the edge, then advance the model.
    task automatic step();
        last_cyc = cyc;
        #2;
        modelEval();
        checkOutput("i_gnt", LW'(i_gnt), LW'(e_igt));
        checkOutput("d_gnt", LW'(d_gnt), LW'(e_dgt));
        checkOutput("i_dvalid", LW'(i_dvalid), LW'(e_idv));
        checkOutput("d_dvalid", LW'(d_dvalid), LW'(e_ddv));
        checkOutput("i_err", LW'(i_err), LW'(e_ier));
        checkOutput("d_err", LW'(d_err), LW'(e_der));
        checkOutput("rdata", rdata, e_rdata);
        checkOutput("l2_req", LW'(l2_req), LW'(m_l2req));
        checkOutput("l2_we", LW'(l2_we), LW'(m_we));
        checkOutput("l2_addr", LW'(l2_addr), LW'(m_addr));
        checkOutput("l2_write_data", l2_write_data, m_wdata);
        last_igt   = (i_gnt === 1'b1);
        last_dgt   = (d_gnt === 1'b1);
        last_idv   = (i_dvalid === 1'b1);
        last_ddv   = (d_dvalid === 1'b1);
        last_der   = (d_err === 1'b1);
        last_l2req = (l2_req === 1'b1);
        if (last_igt) order = {order, "I"};
        if (last_dgt) order = {order, "D"};
        if (l2_auto && last_l2req) l2_cd = l2_lat;
        @(posedge clk);
        modelClock();
        cyc++;
        @(negedge clk);
    endtask

    task automatic envCycle();
        bit    dv;
        dreq_t r;
        dv = stray_dv;
        if (l2_auto && l2_cd == 1) dv = 1;
        if (l2_cd > 0) l2_cd--;
        if (dq.size() > 0) r = dq[0];
        else r = '{we: 1'b0, addr: '0, wdata: '0, lock: 1'b0};
        applyStimulus(i_want, i_next_addr, dq.size() > 0, r.we, r.addr, r.wdata, r.lock, rdy, dv);
        step();
        if (last_igt) i_want = 0;
        if (last_dgt) void'(dq.pop_front());
    endtask

    task automatic drain();
        int n = 0;
        rdy = 1; l2_auto = 1; stray_dv = 0; l2_lat = 2;
        while ((m_busy || dq.size() > 0 || i_want) && n < 600) begin
            envCycle();
            n++;
        end
        if (n >= 600) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got busy after %0d cycles expected idle", n);
        end
        envCycle();
        envCycle();
    endtask

    initial begin
        int g;
        int e;
        bit got_idv;
        dreq_t r;

        rst_n = 0;
        i_want = 0; i_next_addr = '0; rdy = 1; l2_auto = 0; l2_lat = 2; l2_cd = 0; stray_dv = 0;
        order = "";
        modelReset();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 0, 0);
        @(negedge clk);

        // Requests and a data-valid while reset is held must produce nothing.
        applyStimulus(1, 32'h1000, 1, 1, 32'h2000, rndLine(), 1, 1, 1);
        step();
        step();
        rst_n = 1;

        // Lone I read, then simultaneous I and D read.
        tbl[0]  = '{1, 0, 0,  1, 0, 0, 0, 0, 32'h0};
        tbl[1]  = '{0, 0, 0,  0, 0, 1, 0, 0, 32'h1000};
        tbl[2]  = '{0, 0, 0,  0, 0, 0, 0, 0, 32'h0};
        tbl[3]  = '{0, 0, 1,  0, 0, 0, 1, 0, 32'h0};
        tbl[4]  = '{0, 0, 0,  0, 0, 0, 0, 0, 32'h0};
        tbl[5]  = '{1, 1, 0,  0, 1, 0, 0, 0, 32'h0};
        tbl[6]  = '{1, 0, 0,  0, 0, 1, 0, 0, 32'h2000};
        tbl[7]  = '{1, 0, 1,  0, 0, 0, 0, 1, 32'h0};
        tbl[8]  = '{1, 0, 0,  1, 0, 0, 0, 0, 32'h0};
        tbl[9]  = '{0, 0, 0,  0, 0, 1, 0, 0, 32'h1000};
        tbl[10] = '{0, 0, 1,  0, 0, 0, 1, 0, 32'h0};
        tbl[11] = '{0, 0, 0,  0, 0, 0, 0, 0, 32'h0};
        for (int k = 0; k < 12; k++) begin
            applyStimulus(tbl[k].ir, 32'h1000, tbl[k].dr, 1'b0, 32'h2000, '0, 1'b0, 1'b1, tbl[k].dv);
            #1;
            checkOutput($sformatf("row%0d_i_gnt", k), LW'(i_gnt), LW'(tbl[k].e_igt));
            checkOutput($sformatf("row%0d_d_gnt", k), LW'(d_gnt), LW'(tbl[k].e_dgt));
            checkOutput($sformatf("row%0d_l2_req", k), LW'(l2_req), LW'(tbl[k].e_l2req));
            checkOutput($sformatf("row%0d_i_dvalid", k), LW'(i_dvalid), LW'(tbl[k].e_idv));
            checkOutput($sformatf("row%0d_d_dvalid", k), LW'(d_dvalid), LW'(tbl[k].e_ddv));
            if (tbl[k].e_l2req) begin
                checkOutput($sformatf("row%0d_l2_addr", k), LW'(l2_addr), LW'(tbl[k].e_addr));
                checkOutput($sformatf("row%0d_l2_we", k), LW'(l2_we), LW'(0));
            end
            if (tbl[k].e_idv || tbl[k].e_ddv)
                checkOutput($sformatf("row%0d_rdata", k), rdata, l2_read_data);
            step();
        end
        $display("[TB] vector table applied");

        // Streak limit: six back-to-back D reads while I waits.
        drain();
        order = "";
        l2_lat = 1;
        i_want = 1;
        i_next_addr = 32'h3000;
        for (int k = 0; k < 6; k++) dq.push_back('{we: 1'b0, addr: 32'h2000 + 32'(k * 64), wdata: '0, lock: 1'b0});
        for (int n = 0; n < 200 && order.len() < 7; n++) begin
            envCycle();
            if (last_igt) checkOutput("streak_after_i", LW'(dut.streak), LW'(0));
        end
        checkText("streak_order", order, "DDDDIDD");

        // Locked writeback followed by its refill while I waits.
        drain();
        order = "";
        i_want = 1;
        i_next_addr = 32'h5000;
        dq.push_back('{we: 1'b1, addr: 32'h4000, wdata: rndLine(), lock: 1'b1});
        dq.push_back('{we: 1'b0, addr: 32'h2000, wdata: '0, lock: 1'b0});
        for (int n = 0; n < 100 && order.len() < 3; n++) begin
            envCycle();
            if (last_dgt && order == "DD") checkOutput("streak_after_lock", LW'(dut.streak), LW'(1));
        end
        checkText("lock_order", order, "DDI");

        // l2_ready held low for ten cycles.
        drain();
        order = "";
        rdy = 0;
        g = 0;
        dq.push_back('{we: 1'b0, addr: 32'h6000, wdata: '0, lock: 1'b0});
        for (int n = 0; n < 10; n++) begin
            envCycle();
            if (last_dgt || last_igt || last_l2req) g++;
        end
        checkOutput("not_ready_activity", LW'(g), LW'(0));
        rdy = 1;
        envCycle();
        checkOutput("ready_rise_gnt", LW'(last_dgt), LW'(1));

        // L2 never answers: timeout, then a late data-valid in IDLE.
        drain();
        l2_auto = 0;
        g = -1;
        e = -1;
        dq.push_back('{we: 1'b0, addr: 32'h7000, wdata: '0, lock: 1'b0});
        for (int n = 0; n < 5 && g < 0; n++) begin
            envCycle();
            if (last_dgt) g = last_cyc;
        end
        for (int n = 0; n < 400 && e < 0; n++) begin
            envCycle();
            if (last_der) e = last_cyc;
        end
        checkOutput("timeout_wait_cycles", LW'(e - g), LW'(TO + 1));
        stray_dv = 1;
        envCycle();
        stray_dv = 0;
        checkOutput("late_dv_ignored", LW'(last_ddv), LW'(0));
        l2_auto = 1;

        // Reset in the middle of WAIT.
        drain();
        l2_auto = 0;
        i_want = 1;
        i_next_addr = 32'h8000;
        for (int n = 0; n < 5 && i_want; n++) envCycle();
        envCycle();
        envCycle();
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 1, 1);
        #1 rst_n = 0;
        #1;
        checkOutput("rst_i_dvalid", LW'(i_dvalid), LW'(0));
        checkOutput("rst_i_err", LW'(i_err), LW'(0));
        checkOutput("rst_d_dvalid", LW'(d_dvalid), LW'(0));
        checkOutput("rst_rdata", rdata, '0);
        checkOutput("rst_l2_addr", LW'(l2_addr), LW'(0));
        checkOutput("rst_l2_req", LW'(l2_req), LW'(0));
        modelReset();
        l2_cd = 0;
        i_want = 0;
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, '0, 0, 0, '0, '0, 0, 1, 0);
        rst_n = 1;
        l2_auto = 1;
        l2_lat = 2;
        i_want = 1;
        i_next_addr = 32'h9000;
        got_idv = 0;
        for (int n = 0; n < 20 && !got_idv; n++) begin
            envCycle();
            if (last_idv) got_idv = 1;
        end
        checkOutput("post_reset_i_read", LW'(got_idv), LW'(1));

        // Random traffic against the model.
        drain();
        for (int n = 0; n < 1500; n++) begin
            if (!i_want && $urandom_range(3) == 0) begin
                i_want = 1;
                i_next_addr = $urandom();
            end
            if (dq.size() < 2 && $urandom_range(2) == 0) begin
                r.we    = $urandom_range(1);
                r.addr  = $urandom();
                r.wdata = rndLine();
                r.lock  = ($urandom_range(3) == 0);
                dq.push_back(r);
            end
            rdy      = ($urandom_range(9) < 7);
            stray_dv = ($urandom_range(29) == 0);
            l2_lat   = $urandom_range(5, 1);
            envCycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
